skew_buffer: RTL

SKEW_BUFFER -- requirements
Module: skew_buffer

---
 rtl/skew_buffer_pkg.sv | 25 ++
 rtl/skew_buffer_lane.sv | 53 +++++
 rtl/skew_buffer.sv | 84 ++++++++
 3 files changed

// File: rtl/skew_buffer_pkg.sv
// Shared definitions for the skew buffer: mode encoding and lane packing/delay helpers.
package skew_buffer_pkg;

   typedef enum logic {
      MODE_SKEW   = 1'b0,
      MODE_DESKEW = 1'b1
   } mode_e;

   localparam int LANES_MIN  = 2;
   localparam int LANES_MAX  = 64;
   localparam int LANE_W_MAX = 32;

   function automatic int lane_lsb(input int lane, input int lane_w);
      return lane * lane_w;
   endfunction

   function automatic int mirror(input int lane, input int lanes);
      return lanes - 1 - lane;
   endfunction

   function automatic int max_delay(input int lanes);
      return lanes;
   endfunction

endpackage

// File: rtl/skew_buffer_lane.sv
// Single-lane delay line of DEPTH stages; every stage carries data plus its valid bit.
module skew_lane #(
   parameter int LANE_W = 5,
   parameter int DEPTH  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              in_valid,
   input  logic [LANE_W-1:0] in_data,
   output logic [LANE_W-1:0] out_data,
   output logic              out_valid,
   output logic              pend,
   output logic              pend_next
);

   logic [DEPTH-1:0][LANE_W-1:0] data_q, data_d;
   logic [DEPTH-1:0]             vld_q, vld_d;

   always_comb begin
      data_d    = data_q;
      vld_d     = vld_q;
      pend      = 1'b0;
      pend_next = 1'b0;
      if (en) begin
         data_d[0] = in_valid ? in_data : '0;
         vld_d[0]  = in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
      end
      // pend covers elements not yet presented on the output stage
      for (int i = 0; i < DEPTH - 1; i++) begin
         pend      = pend | vld_q[i];
         pend_next = pend_next | vld_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         vld_q  <= '0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
      end
   end

   assign out_valid = vld_q[DEPTH-1];
   assign out_data  = vld_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/skew_buffer.sv
// Skew/deskew buffer: physical lane j has depth j+1; deskew mode mirrors lanes in and out
// so the same triangular storage serves both directions.
module skew_buffer
   import skew_buffer_pkg::*;
#(
   parameter int LANES   = 16,
   parameter int LANE_W  = 5,
   parameter int REVERSE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     mode,
   input  logic                     in_valid,
   input  logic [LANES*LANE_W-1:0]  in_data,
   output logic [LANES*LANE_W-1:0]  out_data,
   output logic [LANES-1:0]         out_lane_valid,
   output logic                     busy,
   output logic                     drain_done
);

   logic [LANES-1:0][LANE_W-1:0] ph_in, ph_out;
   logic [LANES-1:0]             ph_vld, ph_pend, ph_pend_next;
   logic [LANES*LANE_W-1:0]      map_data;
   logic [LANES-1:0]             map_vld;
   mode_e                        mode_q, mode_d, mode_use;
   logic                         drain_done_q, drain_done_d;
   logic                         pend_any, pend_any_next, accept_new;

   always_comb begin
      pend_any      = |ph_pend;
      pend_any_next = |ph_pend_next;
      accept_new    = en && in_valid && !pend_any;
      mode_use      = accept_new ? mode_e'(mode) : mode_q;
      mode_d        = mode_use;
      drain_done_d  = en && pend_any && !pend_any_next;
      map_data      = '0;
      map_vld       = '0;
      for (int j = 0; j < LANES; j++) begin
         ph_in[j] = in_data[lane_lsb((mode_use == MODE_DESKEW) ? mirror(j, LANES) : j, LANE_W) +: LANE_W];
      end
      // contents of the buffer always belong to mode_q: the mode only moves while nothing is pending
      for (int j = 0; j < LANES; j++) begin
         int src, dst;
         src = (mode_q == MODE_DESKEW) ? mirror(j, LANES) : j;
         dst = (REVERSE != 0) ? mirror(src, LANES) : src;
         map_data[lane_lsb(dst, LANE_W) +: LANE_W] = ph_out[j];
         map_vld[dst] = ph_vld[j];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      skew_lane #(
         .LANE_W (LANE_W),
         .DEPTH  (g + 1)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .in_valid  (in_valid),
         .in_data   (ph_in[g]),
         .out_data  (ph_out[g]),
         .out_valid (ph_vld[g]),
         .pend      (ph_pend[g]),
         .pend_next (ph_pend_next[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q       <= MODE_SKEW;
         drain_done_q <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         drain_done_q <= drain_done_d;
      end
   end

   assign out_data       = rst ? '0 : map_data;
   assign out_lane_valid = rst ? '0 : map_vld;
   assign busy           = !rst && pend_any;
   assign drain_done     = !rst && drain_done_q;

endmodule
